// File: rtl/stream_to_seq_bp_pkg.sv
// stream_to_seq_bp_pkg
// Shared helpers for the stream-to-sequential converter: a parameter
// legality check used at elaboration and the width of the per-lane
// occupancy / credit counters (they must hold 0..DEPTH inclusive).
package stream_to_seq_bp_pkg;

   // Returns 1 when the group count divides the beat, the release gap is
   // at least one cycle and each lane FIFO holds at least two beats.
   function automatic bit params_legal(int in_nb, int seq, int gap, int depth);
      if (seq < 1) return 1'b0;
      if ((in_nb % seq) != 0) return 1'b0;
      if (gap < 1) return 1'b0;
      if (depth < 2) return 1'b0;
      return 1'b1;
   endfunction

   // Counters run from 0 up to and including DEPTH.
   function automatic int cnt_width(int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/stream_to_seq_bp_if.sv
// stream_to_seq_bp_if
// Bundles the input beat handshake and the per-group output handshakes.
//   in_data/in_vld/in_rdy : full input beat, IN_NB coefs of WIDTH bits
//   out_data              : same layout as in_data, group g valid per out_vld[g]
//   out_vld/out_rdy       : one handshake pair per output group
//   busy                  : data or release tokens still inside the block
// The slave modport is the converter side, master is the producer/consumer.
interface stream_to_seq_bp_if #(
   parameter int WIDTH = 8,
   parameter int IN_NB = 8,
   parameter int SEQ   = 2
);
   logic [IN_NB*WIDTH-1:0] in_data;
   logic                   in_vld;
   logic                   in_rdy;
   logic [IN_NB*WIDTH-1:0] out_data;
   logic [SEQ-1:0]         out_vld;
   logic [SEQ-1:0]         out_rdy;
   logic                   busy;

   modport master (
      output in_data, in_vld, out_rdy,
      input  in_rdy, out_data, out_vld, busy
   );

   modport slave (
      input  in_data, in_vld, out_rdy,
      output in_rdy, out_data, out_vld, busy
   );
endinterface

// File: rtl/stream_to_seq_bp_lane.sv
// stream_to_seq_bp_lane
// One output group: a first-word-fall-through FIFO, a GAP-stage token line
// fed by the previous lane's pops, and a credit counter of released beats.
//   clk, s_rst      : clock, synchronous active-high reset
//   push, push_data : write one group into the FIFO
//   rdy             : downstream ready for this group
//   tok_in          : previous lane popped a beat this cycle
//   vld, head       : group available / FIFO head data
//   room            : FIFO not full (registered count only)
//   busy            : FIFO non-empty or token still travelling
// With HAS_CREDIT=0 the head is valid whenever the FIFO is non-empty.
module stream_to_seq_bp_lane
   import stream_to_seq_bp_pkg::*;
#(
   parameter int DW         = 32,
   parameter int DEPTH      = 4,
   parameter int GAP        = 1,
   parameter int HAS_CREDIT = 1
) (
   input  logic          clk,
   input  logic          s_rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          rdy,
   input  logic          tok_in,
   output logic          vld,
   output logic [DW-1:0] head,
   output logic          room,
   output logic          busy
);
   localparam int CW = cnt_width(DEPTH);
   localparam int PW = $clog2(DEPTH);

   logic [DW-1:0]  mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic [CW-1:0]  credit;
   logic [GAP-1:0] line;
   logic           tok_out;
   logic           pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // A token at the end of the line makes its beat eligible in that same
   // cycle, so the release lands exactly GAP cycles after the upstream pop.
   assign tok_out = line[GAP-1];
   assign vld     = (count != '0) && ((HAS_CREDIT == 0) || (credit != '0) || tok_out);
   assign pop     = vld & rdy;
   assign head    = mem[rd_ptr];
   assign room    = (count < CW'(DEPTH));
   assign busy    = (count != '0) || (line != '0);

   // Pointers, occupancy, token line and credits. A token leaving the line
   // adds a credit, a pop spends one; both together leave it unchanged.
   always_ff @(posedge clk) begin
      if (s_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         credit <= '0;
         line   <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop) count <= count + CW'(1);
         else if (!push && pop) count <= count - CW'(1);
         line[0] <= tok_in;
         for (int i = 1; i < GAP; i++) line[i] <= line[i-1];
         if (HAS_CREDIT != 0) begin
            if (tok_out && !pop) credit <= credit + CW'(1);
            else if (!tok_out && pop) credit <= credit - CW'(1);
         end
      end
   end

   // Storage is not reset; contents are only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

`ifndef SYNTHESIS
   // Every credit or travelling token belongs to a beat still held here.
   always_ff @(posedge clk) begin
      if (!s_rst && (HAS_CREDIT != 0)) begin
         assert (credit <= count);
         assert (($countones(line) + int'(credit)) <= int'(count));
      end
   end
`endif

endmodule

// File: rtl/stream_to_seq_bp.sv
// stream_to_seq_bp
// Splits each IN_NB-coef input beat into SEQ groups delivered one after the
// other; group g is released GAP cycles after group g-1 of the same beat was
// popped, and every group has its own backpressure.
//   clk   : clock
//   s_rst : synchronous active-high reset
//   bus   : stream_to_seq_bp_if.slave (in_data/in_vld/in_rdy,
//           out_data/out_vld/out_rdy, busy)
// Optional macro STREAM_TO_SEQ_BP_BYPASS_EN: when lane 0 is empty an accepted
// beat's group 0 is presented in the same cycle and, if popped, never stored.
module stream_to_seq_bp
   import stream_to_seq_bp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int IN_NB = 8,
   parameter int SEQ   = 2,
   parameter int GAP   = 1,
   parameter int DEPTH = 4
) (
   input logic               clk,
   input logic               s_rst,
   stream_to_seq_bp_if.slave bus
);
   localparam int C  = IN_NB / SEQ;
   localparam int GW = C * WIDTH;

`ifndef SYNTHESIS
   if (!params_legal(IN_NB, SEQ, GAP, DEPTH)) begin : g_bad_params
      $fatal(1, "stream_to_seq_bp: illegal SEQ, GAP or DEPTH");
   end
`endif

   logic [SEQ-1:0]         lane_vld;
   logic [SEQ-1:0]         lane_room;
   logic [SEQ-1:0]         lane_busy;
   logic [SEQ-1:0]         push;
   logic [SEQ-1:0]         pop;
   logic [SEQ-1:0]         tok;
   logic [IN_NB*WIDTH-1:0] lane_data;
   logic [SEQ-1:0]         out_vld_c;
   logic [IN_NB*WIDTH-1:0] out_data_c;
   logic                   in_rdy;
   logic                   accept;

   // Ready only looks at registered occupancy and is held low during reset.
   assign in_rdy = ~s_rst & (&lane_room);
   assign accept = bus.in_vld & in_rdy;

`ifdef STREAM_TO_SEQ_BP_BYPASS_EN
   logic bypass;
   assign bypass = accept & ~lane_vld[0];
`endif

   // Output selection and lane writes. With the bypass, an empty lane 0
   // shows the incoming group directly and skips the write if it is taken.
   always_comb begin
      out_vld_c  = lane_vld;
      out_data_c = lane_data;
      push       = {SEQ{accept}};
`ifdef STREAM_TO_SEQ_BP_BYPASS_EN
      if (bypass) begin
         out_vld_c[0]       = 1'b1;
         out_data_c[GW-1:0] = bus.in_data[GW-1:0];
         push[0]            = ~bus.out_rdy[0];
      end
`endif
   end

   // A pop on lane g-1 is the release token for lane g.
   assign pop = out_vld_c & bus.out_rdy;
   assign tok = pop << 1;

   for (genvar g = 0; g < SEQ; g++) begin : g_lane
      stream_to_seq_bp_lane #(
         .DW        (GW),
         .DEPTH     (DEPTH),
         .GAP       (GAP),
         .HAS_CREDIT((g > 0) ? 1 : 0)
      ) u_lane (
         .clk       (clk),
         .s_rst     (s_rst),
         .push      (push[g]),
         .push_data (bus.in_data[g*GW +: GW]),
         .rdy       (bus.out_rdy[g]),
         .tok_in    (tok[g]),
         .vld       (lane_vld[g]),
         .head      (lane_data[g*GW +: GW]),
         .room      (lane_room[g]),
         .busy      (lane_busy[g])
      );
   end

   assign bus.in_rdy   = in_rdy;
   assign bus.out_vld  = out_vld_c;
   assign bus.out_data = out_data_c;
   assign bus.busy     = |lane_busy;

endmodule

// File: tb/tb_stream_to_seq_bp.sv
// tb_stream_to_seq_bp
// Drives stream_to_seq_bp (SEQ=4, GAP=2, DEPTH=8) through directed steps and
// a randomized phase. The reference keeps, per beat, its accept cycle and the
// cycle each group left; a lane head is valid once its release time is due.
module tb_stream_to_seq_bp;
   localparam int WIDTH = 8;
   localparam int IN_NB = 8;
   localparam int SEQ   = 4;
   localparam int GAP   = 2;
   localparam int DEPTH = 8;
   localparam int DW    = IN_NB * WIDTH;
   localparam int GW    = DW / SEQ;
   localparam int MAXB  = 2048;
   localparam int NEVER = 1 << 29;

   logic clk = 1'b0;
   logic s_rst;

   stream_to_seq_bp_if #(.WIDTH(WIDTH), .IN_NB(IN_NB), .SEQ(SEQ)) bus ();

   stream_to_seq_bp #(
      .WIDTH(WIDTH), .IN_NB(IN_NB), .SEQ(SEQ), .GAP(GAP), .DEPTH(DEPTH)
   ) dut (
      .clk  (clk),
      .s_rst(s_rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int assertCount = 0;
   int failCount   = 0;
   int cyc         = 0;
   int nextBeat    = 0;
   int dirVld      = -1;
   int handshakes  = 0;
   logic [DW-1:0] beatData [MAXB];
   int acceptCyc [MAXB];
   int popCyc [MAXB][SEQ];
   int laneHead [SEQ];

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic vld, input logic [DW-1:0] data, input logic [SEQ-1:0] rdy);
      s_rst       = rst;
      bus.in_vld  = vld;
      bus.in_data = data;
      bus.out_rdy = rdy;
   endtask

   // One clock cycle: drive, sample mid-cycle against the reference, then
   // advance the reference by what the spec says happens at the edge.
   task automatic runCycle(input logic rst, input logic vld, input logic [DW-1:0] data, input logic [SEQ-1:0] rdy);
      logic           expRdy;
      logic           expBusy;
      logic           acc;
      logic [SEQ-1:0] expVld;
      logic [DW-1:0]  expData;
      logic [DW-1:0]  mask;
      int             b;
      int             due;
      applyStimulus(rst, vld, data, rdy);
      @(negedge clk);
      expRdy  = !rst;
      expBusy = 1'b0;
      expVld  = '0;
      expData = '0;
      mask    = '0;
      for (int g = 0; g < SEQ; g++) begin
         if ((nextBeat - laneHead[g]) >= DEPTH) expRdy = 1'b0;
         if (nextBeat != laneHead[g]) expBusy = 1'b1;
      end
      acc = vld && expRdy;
      for (int g = 0; g < SEQ; g++) begin
         if (nextBeat != laneHead[g]) begin
            b = laneHead[g];
            if (g == 0) due = acceptCyc[b] + 1;
            else due = popCyc[b][g-1] + GAP;
            if (due <= cyc) begin
               expVld[g]             = 1'b1;
               expData[g*GW +: GW]   = beatData[b][g*GW +: GW];
               mask[g*GW +: GW]      = '1;
            end
         end
      end
`ifdef STREAM_TO_SEQ_BP_BYPASS_EN
      if (acc && (nextBeat == laneHead[0])) begin
         expVld[0]       = 1'b1;
         expData[GW-1:0] = data[GW-1:0];
         mask[GW-1:0]    = '1;
      end
`endif
      if (dirVld >= 0) checkOutput("directed_out_vld", 64'(bus.out_vld), 64'(dirVld));
      checkOutput("in_rdy", 64'(bus.in_rdy), 64'(expRdy));
      if (!rst) begin
         checkOutput("out_vld", 64'(bus.out_vld), 64'(expVld));
         checkOutput("busy", 64'(bus.busy), 64'(expBusy));
         checkOutput("out_data", 64'(bus.out_data & mask), 64'(expData));
      end
      if (bus.in_vld && bus.in_rdy) handshakes++;
      if (rst) begin
         for (int g = 0; g < SEQ; g++) laneHead[g] = nextBeat;
      end else begin
         if (acc) begin
            beatData[nextBeat]  = data;
            acceptCyc[nextBeat] = cyc;
            for (int g = 0; g < SEQ; g++) popCyc[nextBeat][g] = NEVER;
            nextBeat++;
         end
         for (int g = 0; g < SEQ; g++) begin
            if (expVld[g] && rdy[g]) begin
               popCyc[laneHead[g]][g] = cyc;
               laneHead[g]++;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      int dirTab [9];
      int target;
      int startCyc;
      for (int g = 0; g < SEQ; g++) laneHead[g] = 0;

      $display("[TB] reset");
      repeat (3) runCycle(1'b1, 1'b0, '0, '1);

      $display("[TB] single beat, all lanes ready");
`ifdef STREAM_TO_SEQ_BP_BYPASS_EN
      dirTab = '{1, 0, 2, 0, 4, 0, 8, 0, 0};
`else
      dirTab = '{0, 1, 0, 2, 0, 4, 0, 8, 0};
`endif
      for (int k = 0; k < 9; k++) begin
         dirVld = dirTab[k];
         runCycle(1'b0, k == 0, 64'h8877_6655_4433_2211, '1);
      end
      dirVld = -1;

      $display("[TB] eight back-to-back beats");
      handshakes = 0;
      for (int k = 0; k < 8; k++) runCycle(1'b0, 1'b1, {$urandom, $urandom}, '1);
      checkOutput("b2b_accepted", 64'(handshakes), 64'd8);
      repeat (12) runCycle(1'b0, 1'b0, '0, '1);

      $display("[TB] lane 1 held off");
      handshakes = 0;
      for (int k = 0; k < 14; k++) runCycle(1'b0, 1'b1, {$urandom, $urandom}, 4'b1101);
      checkOutput("bp_accepted", 64'(handshakes), 64'(DEPTH));
      checkOutput("bp_in_rdy_low", 64'(bus.in_rdy), 64'd0);
      repeat (30) runCycle(1'b0, 1'b0, '0, '1);

      $display("[TB] reset with beats stored");
      for (int k = 0; k < 3; k++) runCycle(1'b0, 1'b1, {$urandom, $urandom}, '0);
      repeat (2) runCycle(1'b0, 1'b0, '0, '0);
      checkOutput("pre_reset_busy", 64'(bus.busy), 64'd1);
      runCycle(1'b1, 1'b0, '0, '1);
      dirVld = 0;
      repeat (5) runCycle(1'b0, 1'b0, '0, '1);
      dirVld = -1;

      $display("[TB] random traffic");
      target   = nextBeat + 1000;
      startCyc = cyc;
      while ((nextBeat < target) && ((cyc - startCyc) < 20000)) begin
         runCycle(1'b0, $urandom_range(0, 99) < 70, {$urandom, $urandom}, 4'($urandom));
      end
      checkOutput("random_beats_done", 64'(nextBeat), 64'(target));
      repeat (40) runCycle(1'b0, 1'b0, '0, '1);
      checkOutput("final_busy", 64'(bus.busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
